// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C transaction sequencer: command flag bits,
// FSM encoding, latched request layout and sizing constants.
package i2c_master_pkg;

  localparam int CTL_START = 0;
  localparam int CTL_DRV   = 1;
  localparam int CTL_RCV   = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_RPT   = 4;

  localparam int MAX_CMDS  = 7;
  localparam int MAX_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_GO, S_WAIT, S_POP, S_RESP
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [6:0]  saddr;
    logic [7:0]  reg_addr;
    logic [1:0]  len;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/i2c_master_seq_cmdgen.sv
// Maps a latched request and a command index to the engine command byte and
// flags; also reports how many commands the request expands to.
module i2c_master_seq_cmdgen
  import i2c_master_pkg::*;
(
  input  req_t       req_i,
  input  logic [2:0] idx_i,
  output logic [4:0] ctl_o,
  output logic [7:0] dat_o,
  output logic [2:0] num_o
);

  logic [1:0] bsel;

  always_comb begin
    num_o = req_i.rw ? ({1'b0, req_i.len} + 3'd4) : ({1'b0, req_i.len} + 3'd3);
    ctl_o = '0;
    dat_o = '0;
    bsel  = 2'(idx_i - 3'd2);
    if (idx_i == 3'd0) begin
      dat_o = {req_i.saddr, 1'b0};
      ctl_o[CTL_START] = 1'b1;
      ctl_o[CTL_DRV]   = 1'b1;
    end else if (idx_i == 3'd1) begin
      dat_o = req_i.reg_addr;
      ctl_o[CTL_DRV] = 1'b1;
    end else if (!req_i.rw) begin
      dat_o = req_i.wdata[{bsel, 3'b000} +: 8];
      ctl_o[CTL_DRV] = 1'b1;
    end else if (idx_i == 3'd2) begin
      // repeated start switches the bus direction to read
      dat_o = {req_i.saddr, 1'b1};
      ctl_o[CTL_RPT] = 1'b1;
      ctl_o[CTL_DRV] = 1'b1;
    end else begin
      ctl_o[CTL_RCV] = 1'b1;
    end
    if (idx_i == num_o - 3'd1) ctl_o[CTL_STOP] = 1'b1;
  end

endmodule

// File: rtl/i2c_master_seq.sv
// Register-access sequencer: expands one request into engine commands, runs
// the engine, drains its receive FIFO and returns data plus NACK/timeout status.
module i2c_master_seq
  import i2c_master_pkg::*;
#(
  parameter int P_TX_DEPTH = 8,
  parameter int P_TIMEOUT  = 1_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VLD,
  output logic        REQ_RDY,
  input  logic        REQ_RW,
  input  logic [6:0]  REQ_SADDR,
  input  logic [7:0]  REQ_REG,
  input  logic [1:0]  REQ_LEN,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VLD,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_NACK,
  output logic        RSP_TMO,
  output logic        BUSY,
  input  logic        I2C_EN,
  output logic        I2C_GO,
  output logic [7:0]  I2C_RUN_NUM,
  input  logic        I2C_DONE,
  input  logic        fifo_snd_rdy,
  output logic        fifo_snd_vld,
  output logic [7:0]  fifo_snd_dat,
  output logic [4:0]  fifo_snd_ctl,
  output logic        fifo_rcv_rdy,
  input  logic        fifo_rcv_vld,
  input  logic [7:0]  fifo_rcv_dat,
  input  logic        fifo_rcv_ack
);

  if (P_TX_DEPTH < MAX_CMDS) begin : g_depth_chk
    $error("P_TX_DEPTH must hold a full command run");
  end

  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (P_TIMEOUT > 0) ? TW'(P_TIMEOUT - 1) : '0;
  localparam int BW = $clog2(MAX_BYTES);

  state_t         state_q, state_d;
  req_t           req_q, req_d;
  logic [2:0]     idx_q, idx_d;
  logic [BW-1:0]  rbyte_q, rbyte_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           nack_q, nack_d, tmo_q, tmo_d;
  logic [7:0]     run_num_q, run_num_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;

  logic [4:0] cmd_ctl;
  logic [7:0] cmd_dat;
  logic [2:0] cmd_num;
  logic       last_cmd;

  // idx_q walks the command list twice: once while pushing, once while popping
  i2c_master_seq_cmdgen u_cmdgen (
    .req_i (req_q),
    .idx_i (idx_q),
    .ctl_o (cmd_ctl),
    .dat_o (cmd_dat),
    .num_o (cmd_num)
  );

  assign last_cmd = (idx_q == cmd_num - 3'd1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      idx_q     <= '0;
      rbyte_q   <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      tmo_q     <= 1'b0;
      run_num_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      idx_q     <= idx_d;
      rbyte_q   <= rbyte_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      tmo_q     <= tmo_d;
      run_num_q <= run_num_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    idx_d     = idx_q;
    rbyte_d   = rbyte_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    tmo_d     = tmo_q;
    run_num_d = run_num_q;
    tcnt_d    = tcnt_q;
    if (state_q != S_IDLE && state_q != S_RESP && !I2C_EN) begin
      // engine disabled under us: abort with a timeout-style response
      state_d = S_RESP;
      tmo_d   = 1'b1;
      rdata_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (REQ_VLD && I2C_EN) begin
          state_d   = S_PUSH;
          req_d     = '{rw: REQ_RW, saddr: REQ_SADDR, reg_addr: REQ_REG,
                        len: REQ_LEN, wdata: REQ_WDATA};
          idx_d     = '0;
          rbyte_d   = '0;
          rdata_d   = '0;
          nack_d    = 1'b0;
          tmo_d     = 1'b0;
          run_num_d = '0;
        end
        S_PUSH: if (fifo_snd_rdy) begin
          if (last_cmd) begin
            state_d   = S_GO;
            idx_d     = '0;
            run_num_d = {5'd0, cmd_num};
            tcnt_d    = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_GO, S_WAIT: begin
          if (I2C_DONE) begin
            state_d = S_POP;
          end else if (P_TIMEOUT > 0 && tcnt_q == TMO_LAST) begin
            state_d = S_POP;
            tmo_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            tcnt_d  = tcnt_q + 1'b1;
          end
        end
        S_POP: begin
          if (!fifo_rcv_vld) begin
            state_d = S_RESP;
          end else begin
            if (cmd_ctl[CTL_DRV] && !fifo_rcv_ack) nack_d = 1'b1;
            if (cmd_ctl[CTL_RCV]) begin
              rdata_d[{rbyte_q, 3'b000} +: 8] = fifo_rcv_dat;
              rbyte_d = rbyte_q + 1'b1;
            end
            if (last_cmd) state_d = S_RESP;
            else          idx_d   = idx_q + 3'd1;
          end
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign BUSY         = (state_q != S_IDLE);
  assign REQ_RDY      = (state_q == S_IDLE) && I2C_EN;
  assign fifo_snd_vld = (state_q == S_PUSH) && I2C_EN;
  assign fifo_snd_dat = fifo_snd_vld ? cmd_dat : '0;
  assign fifo_snd_ctl = fifo_snd_vld ? cmd_ctl : '0;
  assign I2C_GO       = (state_q == S_GO || state_q == S_WAIT) && I2C_EN;
  assign I2C_RUN_NUM  = run_num_q;
  assign fifo_rcv_rdy = (state_q == S_POP) && I2C_EN && fifo_rcv_vld;
  assign RSP_VLD      = (state_q == S_RESP);
  assign RSP_RDATA    = RSP_VLD ? rdata_q : '0;
  assign RSP_NACK     = RSP_VLD && nack_q;
  assign RSP_TMO      = RSP_VLD && tmo_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for the I2C sequencer with a simple engine/receive-FIFO model.
module tb_i2c_master_seq;
  logic        CLK = 0, RESET = 1;
  logic        REQ_VLD = 0, REQ_RW = 0;
  logic [6:0]  REQ_SADDR = 0;
  logic [7:0]  REQ_REG = 0;
  logic [1:0]  REQ_LEN = 0;
  logic [31:0] REQ_WDATA = 0;
  logic        REQ_RDY, RSP_VLD, RSP_NACK, RSP_TMO, BUSY, I2C_GO;
  logic [31:0] RSP_RDATA;
  logic [7:0]  I2C_RUN_NUM;
  logic        I2C_EN = 1, I2C_DONE = 0;
  logic        fifo_snd_rdy = 1, fifo_snd_vld;
  logic [7:0]  fifo_snd_dat;
  logic [4:0]  fifo_snd_ctl;
  logic        fifo_rcv_rdy, fifo_rcv_vld, fifo_rcv_ack;
  logic [7:0]  fifo_rcv_dat;

  int tests_run = 0, tests_failed = 0;

  // receive FIFO model: tasks append, DUT pops
  logic [7:0] rq_dat [64];
  logic       rq_ack [64];
  int         rq_n = 0, rq_rd = 0;
  assign fifo_rcv_vld = (rq_rd < rq_n);
  assign fifo_rcv_dat = rq_dat[rq_rd];
  assign fifo_rcv_ack = rq_ack[rq_rd];
  always @(posedge CLK) if (fifo_rcv_rdy && fifo_rcv_vld) rq_rd <= rq_rd + 1;

  always #5 CLK = ~CLK;

  i2c_master_seq #(.P_TX_DEPTH(8), .P_TIMEOUT(100)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_RW(REQ_RW), .REQ_SADDR(REQ_SADDR),
    .REQ_REG(REQ_REG), .REQ_LEN(REQ_LEN), .REQ_WDATA(REQ_WDATA),
    .RSP_VLD(RSP_VLD), .RSP_RDATA(RSP_RDATA), .RSP_NACK(RSP_NACK), .RSP_TMO(RSP_TMO),
    .BUSY(BUSY), .I2C_EN(I2C_EN), .I2C_GO(I2C_GO), .I2C_RUN_NUM(I2C_RUN_NUM),
    .I2C_DONE(I2C_DONE),
    .fifo_snd_rdy(fifo_snd_rdy), .fifo_snd_vld(fifo_snd_vld),
    .fifo_snd_dat(fifo_snd_dat), .fifo_snd_ctl(fifo_snd_ctl),
    .fifo_rcv_rdy(fifo_rcv_rdy), .fifo_rcv_vld(fifo_rcv_vld),
    .fifo_rcv_dat(fifo_rcv_dat), .fifo_rcv_ack(fifo_rcv_ack)
  );

  logic [7:0]  cap_dat [16];
  logic [4:0]  cap_ctl [16];
  int          cap_n, stab_err;
  int          rsp_cnt, rsp_c, lastpop_c;
  logic [31:0] rsp_data;
  logic        rsp_nack, rsp_tmo, rsp_rdy, busy_after;

  task automatic push_rcv(input logic ack, input logic [7:0] dat);
    rq_ack[rq_n] = ack; rq_dat[rq_n] = dat; rq_n++;
  endtask

  task automatic send_req(input logic rw, input logic [6:0] sa, input logic [7:0] rg,
                          input logic [1:0] len, input logic [31:0] wd);
    @(negedge CLK);
    REQ_VLD = 1; REQ_RW = rw; REQ_SADDR = sa; REQ_REG = rg; REQ_LEN = len; REQ_WDATA = wd;
    @(negedge CLK);
    REQ_VLD = 0;
  endtask

  // capture accepted command beats until I2C_GO rises; returns at negedge+1
  task automatic push_collect(input bit toggle);
    bit have_prev = 0;
    logic [7:0] pdat = 0;
    logic [4:0] pctl = 0;
    cap_n = 0; stab_err = 0;
    for (int c = 0; c < 200; c++) begin
      fifo_snd_rdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (I2C_GO) break;
      if (have_prev && (!fifo_snd_vld || fifo_snd_dat !== pdat || fifo_snd_ctl !== pctl)) stab_err++;
      have_prev = 0;
      if (fifo_snd_vld && fifo_snd_rdy && cap_n < 16) begin
        cap_dat[cap_n] = fifo_snd_dat; cap_ctl[cap_n] = fifo_snd_ctl; cap_n++;
      end else if (fifo_snd_vld) begin
        have_prev = 1; pdat = fifo_snd_dat; pctl = fifo_snd_ctl;
      end
      @(negedge CLK);
    end
    fifo_snd_rdy = 1;
  endtask

  task automatic pulse_done();
    @(negedge CLK); I2C_DONE = 1;
    @(negedge CLK); I2C_DONE = 0;
  endtask

  task automatic wait_rsp();
    rsp_cnt = 0; rsp_c = -100; lastpop_c = -1; rsp_data = 0;
    rsp_nack = 0; rsp_tmo = 0; rsp_rdy = 1; busy_after = 1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (fifo_rcv_rdy && fifo_rcv_vld) lastpop_c = c;
      if (c == rsp_c + 1) busy_after = BUSY;
      if (RSP_VLD) begin
        rsp_cnt++; rsp_c = c; rsp_data = RSP_RDATA;
        rsp_nack = RSP_NACK; rsp_tmo = RSP_TMO; rsp_rdy = REQ_RDY;
      end
      if (rsp_cnt > 0 && c > rsp_c + 3) break;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if ({REQ_RDY, BUSY, I2C_GO, fifo_snd_vld, RSP_VLD, fifo_rcv_rdy} !== 6'b100000) begin
      tests_failed++; $display("FAIL reset_outs got %b want 100000", {REQ_RDY, BUSY, I2C_GO, fifo_snd_vld, RSP_VLD, fifo_rcv_rdy}); end
    tests_run++; if (I2C_RUN_NUM !== 8'd0 || RSP_RDATA !== 32'd0) begin
      tests_failed++; $display("FAIL reset_data got %h/%h want 0/0", I2C_RUN_NUM, RSP_RDATA); end
    @(negedge CLK); RESET = 0;
    @(negedge CLK);
  endtask

  task automatic test_write();
    logic [7:0] ed [4] = '{8'hA0, 8'h10, 8'hEF, 8'hBE};
    logic [4:0] ec [4] = '{5'h03, 5'h02, 5'h02, 5'h0A};
    send_req(0, 7'h50, 8'h10, 2'd1, 32'h0000BEEF);
    push_collect(0);
    tests_run++; if (cap_n !== 4) begin tests_failed++; $display("FAIL wr_count got %0d want 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (cap_dat[i] !== ed[i] || cap_ctl[i] !== ec[i]) begin
        tests_failed++; $display("FAIL wr_cmd%0d got %h/%h want %h/%h", i, cap_dat[i], cap_ctl[i], ed[i], ec[i]); end
    end
    tests_run++; if (I2C_RUN_NUM !== 8'd4) begin tests_failed++; $display("FAIL wr_runnum got %0d want 4", I2C_RUN_NUM); end
    for (int i = 0; i < 4; i++) push_rcv(1, 8'h00);
    pulse_done();
    #1;
    tests_run++; if (I2C_GO !== 1'b0) begin tests_failed++; $display("FAIL wr_go_drop got %b want 0", I2C_GO); end
    wait_rsp();
    tests_run++; if (rsp_cnt !== 1 || rsp_nack !== 0 || rsp_tmo !== 0 || rsp_data !== 0) begin
      tests_failed++; $display("FAIL wr_rsp got cnt=%0d nack=%b tmo=%b d=%h want 1/0/0/0", rsp_cnt, rsp_nack, rsp_tmo, rsp_data); end
  endtask

  task automatic test_read();
    logic [7:0] ed [7] = '{8'hA0, 8'h00, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [4:0] ec [7] = '{5'h03, 5'h02, 5'h12, 5'h04, 5'h04, 5'h04, 5'h0C};
    send_req(1, 7'h50, 8'h00, 2'd3, 32'hFFFF_FFFF);
    push_collect(0);
    tests_run++; if (cap_n !== 7) begin tests_failed++; $display("FAIL rd_count got %0d want 7", cap_n); end
    for (int i = 0; i < 7; i++) begin
      tests_run++; if (cap_dat[i] !== ed[i] || cap_ctl[i] !== ec[i]) begin
        tests_failed++; $display("FAIL rd_cmd%0d got %h/%h want %h/%h", i, cap_dat[i], cap_ctl[i], ed[i], ec[i]); end
    end
    tests_run++; if (I2C_RUN_NUM !== 8'd7) begin tests_failed++; $display("FAIL rd_runnum got %0d want 7", I2C_RUN_NUM); end
    for (int i = 0; i < 3; i++) push_rcv(1, 8'h00);
    push_rcv(1, 8'h11); push_rcv(1, 8'h22); push_rcv(1, 8'h33); push_rcv(1, 8'h44);
    pulse_done();
    wait_rsp();
    tests_run++; if (rsp_cnt !== 1 || rsp_data !== 32'h44332211 || rsp_nack !== 0 || rsp_tmo !== 0) begin
      tests_failed++; $display("FAIL rd_rsp got cnt=%0d d=%h nack=%b tmo=%b want 1/44332211/0/0", rsp_cnt, rsp_data, rsp_nack, rsp_tmo); end
    tests_run++; if (rsp_c - lastpop_c !== 1) begin tests_failed++; $display("FAIL rd_latency got %0d want 1", rsp_c - lastpop_c); end
    tests_run++; if (rsp_rdy !== 1'b0) begin tests_failed++; $display("FAIL rd_rdy_in_resp got %b want 0", rsp_rdy); end
  endtask

  task automatic test_nack();
    send_req(0, 7'h50, 8'h10, 2'd0, 32'h0000_0012);
    push_collect(0);
    tests_run++; if (cap_n !== 3) begin tests_failed++; $display("FAIL nk_count got %0d want 3", cap_n); end
    push_rcv(0, 8'h00); push_rcv(1, 8'h00); push_rcv(1, 8'h00);
    pulse_done();
    wait_rsp();
    tests_run++; if (rsp_cnt !== 1 || rsp_nack !== 1'b1) begin
      tests_failed++; $display("FAIL nk_rsp got cnt=%0d nack=%b want 1/1", rsp_cnt, rsp_nack); end
    tests_run++; if (busy_after !== 1'b0 || REQ_RDY !== 1'b1) begin
      tests_failed++; $display("FAIL nk_idle got busy=%b rdy=%b want 0/1", busy_after, REQ_RDY); end
  endtask

  task automatic test_timeout();
    int go_cyc = 0;
    send_req(0, 7'h22, 8'h01, 2'd0, 32'h0);
    push_collect(0);
    if (I2C_GO) go_cyc = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK); #1;
      if (I2C_GO) go_cyc++; else break;
    end
    tests_run++; if (go_cyc !== 100) begin tests_failed++; $display("FAIL tmo_go_cycles got %0d want 100", go_cyc); end
    wait_rsp();
    tests_run++; if (rsp_cnt !== 1 || rsp_tmo !== 1'b1) begin
      tests_failed++; $display("FAIL tmo_rsp got cnt=%0d tmo=%b want 1/1", rsp_cnt, rsp_tmo); end
  endtask

  task automatic test_rdy_toggle();
    logic [7:0] ed [6] = '{8'hA0, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [4:0] ec [6] = '{5'h03, 5'h02, 5'h02, 5'h02, 5'h02, 5'h0A};
    send_req(0, 7'h50, 8'h10, 2'd3, 32'hDDCC_BBAA);
    push_collect(1);
    tests_run++; if (cap_n !== 6) begin tests_failed++; $display("FAIL tg_count got %0d want 6", cap_n); end
    tests_run++; if (stab_err !== 0) begin tests_failed++; $display("FAIL tg_stable got %0d want 0", stab_err); end
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (cap_dat[i] !== ed[i] || cap_ctl[i] !== ec[i]) begin
        tests_failed++; $display("FAIL tg_cmd%0d got %h/%h want %h/%h", i, cap_dat[i], cap_ctl[i], ed[i], ec[i]); end
    end
    for (int i = 0; i < 6; i++) push_rcv(1, 8'h00);
    pulse_done();
    wait_rsp();
    tests_run++; if (rsp_cnt !== 1 || rsp_nack !== 0) begin
      tests_failed++; $display("FAIL tg_rsp got cnt=%0d nack=%b want 1/0", rsp_cnt, rsp_nack); end
  endtask

  task automatic test_en_drop();
    send_req(1, 7'h33, 8'h04, 2'd0, 32'h0);
    push_collect(0);
    @(negedge CLK); I2C_EN = 0; #1;
    tests_run++; if (I2C_GO !== 1'b0) begin tests_failed++; $display("FAIL en_go got %b want 0", I2C_GO); end
    wait_rsp();
    tests_run++; if (rsp_cnt !== 1 || rsp_tmo !== 1'b1 || rsp_data !== 32'd0) begin
      tests_failed++; $display("FAIL en_rsp got cnt=%0d tmo=%b d=%h want 1/1/0", rsp_cnt, rsp_tmo, rsp_data); end
    I2C_EN = 1;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_push();
    fifo_snd_rdy = 0;
    send_req(0, 7'h50, 8'h10, 2'd2, 32'h00123456);
    fifo_snd_rdy = 0; #1;
    tests_run++; if (fifo_snd_vld !== 1'b1 || BUSY !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre got vld=%b busy=%b want 1/1", fifo_snd_vld, BUSY); end
    #2 RESET = 1; #1;
    tests_run++; if ({REQ_RDY, BUSY, I2C_GO, fifo_snd_vld, RSP_VLD} !== 5'b10000 || fifo_snd_ctl !== 5'd0) begin
      tests_failed++; $display("FAIL rst_async got %b/%h want 10000/00", {REQ_RDY, BUSY, I2C_GO, fifo_snd_vld, RSP_VLD}, fifo_snd_ctl); end
    @(negedge CLK); RESET = 0; fifo_snd_rdy = 1;
    wait_rsp();
    tests_run++; if (rsp_cnt !== 0 || BUSY !== 1'b0) begin
      tests_failed++; $display("FAIL rst_no_rsp got cnt=%0d busy=%b want 0/0", rsp_cnt, BUSY); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_rdy_toggle();
    test_en_drop();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Hardware transaction sequencer in front of the I2C master byte engine.
- Turns one register-level request (slave address, register, 1-4 data bytes, read or write) into the byte-command stream the engine consumes: start/drive/receive/stop/repeat.
- Runs the engine, then drains its receive FIFO and returns read data plus a NACK/timeout status.
- Lets a requester (CPU bridge or boot-ROM loader) do complete register accesses without byte-level CSR traffic.

Parameters:
- P_TX_DEPTH, 8, depth of the engine send FIFO; must be >= 7.
- P_TIMEOUT, 1_000_000, CLK cycles allowed between I2C_GO rising and I2C_DONE; 0 disables the timeout.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- REQ_VLD  in  1  request valid
- REQ_RDY  out  1  request accepted when REQ_VLD&REQ_RDY
- REQ_RW  in  1  1=read, 0=write
- REQ_SADDR  in  7  7-bit slave address
- REQ_REG  in  8  register address byte
- REQ_LEN  in  2  byte count minus 1 (0..3 means 1..4 bytes)
- REQ_WDATA  in  32  write data, byte0 = [7:0], sent first
- RSP_VLD  out  1  one-cycle response strobe
- RSP_RDATA  out  32  read data, first byte received in [7:0], unused bytes 0
- RSP_NACK  out  1  some drive byte was not acknowledged
- RSP_TMO  out  1  timeout abort
- BUSY  out  1  high whenever the state is not IDLE
- I2C_EN  in  1  engine enabled
- I2C_GO  out  1  run request to the engine
- I2C_RUN_NUM  out  8  number of commands queued for this run
- I2C_DONE  in  1  engine run complete
- fifo_snd_rdy  in  1  send FIFO ready
- fifo_snd_vld  out  1  send FIFO valid
- fifo_snd_dat  out  8  command byte
- fifo_snd_ctl  out  5  command flags: bit0 start, bit1 drive, bit2 receive, bit3 stop, bit4 repeat
- fifo_rcv_rdy  out  1  receive FIFO pop
- fifo_rcv_vld  in  1  receive FIFO valid
- fifo_rcv_dat  in  8  received byte
- fifo_rcv_ack  in  1  1 = slave acknowledged the corresponding drive byte

Behaviour:
- Reset: all outputs 0 except REQ_RDY=1; state IDLE.
- FSM states: IDLE, PUSH, GO, WAIT, POP, RESP.
- IDLE:
  - REQ_RDY = I2C_EN.
  - On accept, latch all REQ_* fields, clear the counters, go to PUSH.
- PUSH issues one command per fifo_snd_vld&fifo_snd_rdy beat. fifo_snd_vld/dat/ctl are held stable until rdy.
- Write request, N=LEN+1, total N+2 commands:
  - {SADDR,0} with start|drive
  - REG with drive
  - data bytes 0..N-1 with drive; the last byte also has stop.
- Read request, total N+3 commands:
  - {SADDR,0} with start|drive
  - REG with drive
  - {SADDR,1} with repeat|drive
  - N commands with receive and dat=0; the last also has stop.
- After the last beat:
  - I2C_RUN_NUM = command count.
  - Go to GO, which asserts I2C_GO the next cycle.
- GO/WAIT:
  - I2C_GO held high until I2C_DONE is sampled high, then deasserted the following cycle.
  - The timeout counter runs from GO entry. If it reaches P_TIMEOUT: drop I2C_GO, set the TMO flag, go to POP.
- POP:
  - Assert fifo_rcv_rdy while fifo_rcv_vld.
  - Every drive-command entry with ack=0 sets the NACK flag.
  - Receive entries are packed into RSP_RDATA byte k in arrival order.
  - Exactly one entry per command is expected; pop until count reached or fifo_rcv_vld=0.
- RESP:
  - RSP_VLD=1 for one cycle with the latched data and flags, then IDLE.
  - Latency from the last pop to RSP_VLD is 1 cycle.
- I2C_EN falling in any state other than IDLE:
  - Drop I2C_GO and fifo_snd_vld.
  - Go to RESP with RSP_TMO=1 and RSP_RDATA=0.
- RESET mid-operation: immediate return to IDLE. No response is issued.
- No new request is accepted while BUSY, and REQ_RDY=0 during RESP.

Decomposition:
- Shared package i2c_master_pkg holds:
  - the command-flag bit positions (START=0, DRV=1, RCV=2, STOP=3, RPT=4)
  - the FSM state encoding
  - constants MAX_CMDS=7 and MAX_BYTES=4.
- One natural sub-module, i2c_master_seq_cmdgen: combinational mapping of (RW, index, latched fields) to {ctl,dat}, plus the command count.

Test Plan:
- Write SADDR=0x50, REG=0x10, LEN=1, WDATA=0x0000BEEF, all acks=1:
  - send stream {A0,start|drv}, {10,drv}, {EF,drv}, {BE,drv|stop}
  - RUN_NUM=4, RSP_NACK=0.
- Read SADDR=0x50, REG=0x00, LEN=3; engine returns 3 ack entries then bytes 11,22,33,44:
  - RUN_NUM=7, RSP_RDATA=0x44332211, RSP_NACK=0.
- Write with ack=0 on the address byte: RSP_NACK=1, RSP_VLD exactly once, FSM back to IDLE.
- P_TIMEOUT=100, I2C_DONE never asserted: I2C_GO drops at cycle 100, RSP_TMO=1.
- fifo_snd_rdy toggled randomly during PUSH: no command lost or duplicated; dat/ctl stable while vld&!rdy.
- I2C_EN deasserted during WAIT: RSP_TMO=1, I2C_GO=0. Asserting RESET mid-PUSH returns all outputs to reset values asynchronously.
